// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the key-schedule datapath.
// Holds key-size encodings, per-size Nk/N/Nr tables and the FSM state type.
package aes_pkg;

   typedef enum logic [1:0] {
      KS_128 = 2'b00,
      KS_192 = 2'b01,
      KS_256 = 2'b10
   } key_size_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_EXPAND = 1'b1
   } state_e;

   localparam logic [3:0] NK_128 = 4'd4;
   localparam logic [3:0] NK_192 = 4'd6;
   localparam logic [3:0] NK_256 = 4'd8;
   localparam logic [5:0] N_128  = 6'd44;
   localparam logic [5:0] N_192  = 6'd52;
   localparam logic [5:0] N_256  = 6'd60;
   localparam logic [3:0] NR_128 = 4'd10;
   localparam logic [3:0] NR_192 = 4'd12;
   localparam logic [3:0] NR_256 = 4'd14;
   localparam logic [7:0] RCON_INIT = 8'h01;

   // Encoding 11 falls into the AES-256 branch because bit 1 is tested first.
   function automatic logic [3:0] nk_words(input logic [1:0] nk);
      if (nk[1]) return NK_256;
      else if (nk == KS_192) return NK_192;
      else return NK_128;
   endfunction

   function automatic logic [5:0] n_words(input logic [1:0] nk);
      if (nk[1]) return N_256;
      else if (nk == KS_192) return N_192;
      else return N_128;
   endfunction

   function automatic logic [3:0] n_rounds(input logic [1:0] nk);
      if (nk[1]) return NR_256;
      else if (nk == KS_192) return NR_192;
      else return NR_128;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Key-load request and round-key output bundle of the AES key expander.
interface aes_key_expander_if;
   logic [1:0]   in_nk;
   logic         in_valid;
   logic [255:0] in_key;
   logic         in_ready;
   logic         out_valid;
   logic [127:0] out_rk;
   logic         out_last;
   logic [1:0]   out_nk;

   modport master (
      output in_nk, in_valid, in_key,
      input  in_ready, out_valid, out_rk, out_last, out_nk
   );

   modport slave (
      input  in_nk, in_valid, in_key,
      output in_ready, out_valid, out_rk, out_last, out_nk
   );
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse (x^254) followed by the affine map.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240, w_inv;

   // Addition chain 2,3,6,12,15,30,60,120,240 then 240+12+2 = 254; zero maps to zero.
   assign w_x2   = gf_mul(i_byte, i_byte);
   assign w_x3   = gf_mul(w_x2, i_byte);
   assign w_x6   = gf_mul(w_x3, w_x3);
   assign w_x12  = gf_mul(w_x6, w_x6);
   assign w_x15  = gf_mul(w_x12, w_x3);
   assign w_x30  = gf_mul(w_x15, w_x15);
   assign w_x60  = gf_mul(w_x30, w_x30);
   assign w_x120 = gf_mul(w_x60, w_x60);
   assign w_x240 = gf_mul(w_x120, w_x120);
   assign w_inv  = gf_mul(gf_mul(w_x240, w_x12), w_x2);

   assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                 ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule, one word per cycle, one round key per 4 words.
// Build option KEYEXP_ZEROIZE_EN clears key material the cycle after the final round key.
module aes_key_expander
   import aes_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   aes_key_expander_if.slave bus
);

   state_e       r_state, w_next_state;
   logic [255:0] r_key;
   logic [1:0]   r_nk;
   logic [5:0]   r_idx;
   logic [2:0]   r_cnt;
   logic [7:0]   r_rcon;
   logic [31:0]  r_win [8];
   logic [95:0]  r_asm;
   logic         r_out_valid, r_out_last;
   logic [127:0] r_out_rk;

   logic         w_accept, w_is_key, w_rot_step, w_sub_step, w_last_word;
   logic [3:0]   w_nk_words;
   logic [2:0]   w_nk_m1;
   logic [31:0]  w_key_word, w_prev, w_old, w_sb_in, w_sb_out, w_temp, w_new;

   assign w_accept    = bus.in_valid & (r_state == ST_IDLE);
   assign w_nk_words  = nk_words(r_nk);
   assign w_nk_m1     = w_nk_words[2:0] - 3'd1;
   assign w_key_word  = r_key[8'd255 - {r_idx[2:0], 5'd0} -: 32];
   assign w_prev      = r_win[0];
   assign w_old       = r_win[w_nk_m1];
   assign w_is_key    = (r_idx < {2'b00, w_nk_words});
   // r_cnt counts down to the next multiple of Nk; 4 left means i mod 8 == 4 for AES-256.
   assign w_rot_step  = (r_cnt == 3'd0);
   assign w_sub_step  = r_nk[1] & (r_cnt == 3'd4);
   assign w_last_word = (r_idx == (n_words(r_nk) - 6'd1));
   assign w_sb_in     = w_rot_step ? {w_prev[23:0], w_prev[31:24]} : w_prev;

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
         .i_byte (w_sb_in[8*g +: 8]),
         .o_byte (w_sb_out[8*g +: 8])
      );
   end

   // Next schedule word from the key or from the sliding window.
   always_comb begin
      w_temp = w_prev;
      w_new  = w_key_word;
      if (w_rot_step) w_temp = w_sb_out ^ {r_rcon, 24'h000000};
      else if (w_sub_step) w_temp = w_sb_out;
      else w_temp = w_prev;
      if (w_is_key) w_new = w_key_word;
      else w_new = w_old ^ w_temp;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else r_state <= w_next_state;
   end

   // FSM next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:   if (w_accept) w_next_state = ST_EXPAND; else w_next_state = ST_IDLE;
         ST_EXPAND: if (w_last_word) w_next_state = ST_IDLE; else w_next_state = ST_EXPAND;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   // Key latch, counters, window, assembly register and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_key       <= 256'h0;
         r_nk        <= 2'b00;
         r_idx       <= 6'd0;
         r_cnt       <= 3'd0;
         r_rcon      <= 8'h00;
         r_asm       <= 96'h0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_rk    <= 128'h0;
         for (int k = 0; k < 8; k++) r_win[k] <= 32'h0;
      end else begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
`ifdef KEYEXP_ZEROIZE_EN
         if (r_out_last) begin
            r_key    <= 256'h0;
            r_rcon   <= 8'h00;
            r_asm    <= 96'h0;
            r_out_rk <= 128'h0;
            for (int k = 0; k < 8; k++) r_win[k] <= 32'h0;
         end
`endif
         if (w_accept) begin
            r_key  <= bus.in_key;
            r_nk   <= bus.in_nk;
            r_idx  <= 6'd0;
            r_cnt  <= 3'd0;
            r_rcon <= RCON_INIT;
         end else if (r_state == ST_EXPAND) begin
            r_win[0] <= w_new;
            for (int k = 1; k < 8; k++) r_win[k] <= r_win[k-1];
            r_idx <= r_idx + 6'd1;
            r_cnt <= w_rot_step ? w_nk_m1 : (r_cnt - 3'd1);
            if (!w_is_key && w_rot_step) r_rcon <= xtime(r_rcon);
            r_asm <= {r_asm[63:0], w_new};
            if (r_idx[1:0] == 2'b11) begin
               r_out_rk    <= {r_asm, w_new};
               r_out_valid <= 1'b1;
               r_out_last  <= (r_idx[5:2] == n_rounds(r_nk));
            end
         end
      end
   end

   assign bus.in_ready  = (r_state == ST_IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.out_rk    = r_out_rk;
   assign bus.out_last  = r_out_last;
   assign bus.out_nk    = r_nk;

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander: a reference key schedule fills a queue of
// expected round keys with their arrival cycles; a negedge monitor pops and compares.
module tb_aes_key_expander;

   typedef struct {
      logic [127:0] rk;
      logic         last;
      logic [1:0]   nk;
      int           cyc;
   } exp_t;

   localparam logic [255:0] K1   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K2   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   logic clk;
   logic rst;
   int   cyc;
   int   n_compared;
   int   n_mismatched;
   int   obs_cnt;
   int   last_accept;
   logic [127:0] obs_rk [15];
   logic [31:0]  mdl_w [60];
   exp_t sb[$];
   exp_t mon_e;
   logic post_pend;
   logic [127:0] post_exp;

   aes_key_expander_if bus_if ();

   aes_key_expander dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
      int p, aa, bb;
      p = 0; aa = int'(a); bb = int'(b);
      while (bb != 0) begin
         if ((bb & 1) != 0) p = p ^ aa;
         aa = aa << 1;
         if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
         bb = bb >> 1;
      end
      return p[7:0];
   endfunction

   function automatic logic [7:0] tb_sbox(input logic [7:0] x);
      logic [7:0] inv, s, c;
      logic [7:0] yb;
      inv = 8'h00;
      c = 8'h63;
      for (int y = 1; y < 256; y++) begin
         yb = y[7:0];
         if (tb_gmul(x, yb) == 8'h01) inv = yb;
      end
      for (int k = 0; k < 8; k++)
         s[k] = inv[k] ^ inv[(k+4)%8] ^ inv[(k+5)%8] ^ inv[(k+6)%8] ^ inv[(k+7)%8] ^ c[k];
      return s;
   endfunction

   function automatic logic [31:0] tb_subword(input logic [31:0] w);
      return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
   endfunction

   task automatic model_expand(input logic [1:0] nk, input logic [255:0] key, output int nr);
      int nkw, total, rc;
      logic [31:0] t;
      nkw = nk[1] ? 8 : (nk[0] ? 6 : 4);
      nr = nkw + 6;
      total = 4 * (nr + 1);
      rc = 1;
      for (int i = 0; i < nkw; i++) mdl_w[i] = key[255 - 32*i -: 32];
      for (int i = nkw; i < total; i++) begin
         t = mdl_w[i-1];
         if (i % nkw == 0) begin
            t = tb_subword({t[23:0], t[31:24]}) ^ {rc[7:0], 24'h0};
            rc = rc << 1;
            if (rc > 255) rc = rc ^ 'h11b;
         end else if (nkw == 8 && i % nkw == 4) begin
            t = tb_subword(t);
         end
         mdl_w[i] = mdl_w[i-nkw] ^ t;
      end
   endtask

   // Called at a negedge with the DUT expected idle; returns at the negedge after acceptance.
   task automatic do_load(input logic [1:0] nk, input logic [255:0] key);
      int nr;
      exp_t e;
      check_eq("load_ready", bus_if.in_ready, 1'b1);
      bus_if.in_nk = nk;
      bus_if.in_key = key;
      bus_if.in_valid = 1'b1;
      @(posedge clk);
      #1;
      last_accept = cyc;
      bus_if.in_valid = 1'b0;
      obs_cnt = 0;
      model_expand(nk, key, nr);
      for (int r = 0; r <= nr; r++) begin
         e.rk = {mdl_w[4*r], mdl_w[4*r+1], mdl_w[4*r+2], mdl_w[4*r+3]};
         e.last = (r == nr);
         e.nk = nk;
         e.cyc = last_accept + 4*r + 4;
         sb.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic wait_drain(input int budget);
      int k;
      k = 0;
      while (sb.size() != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check_eq("drain", sb.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (bus_if.out_valid) begin
         if (sb.size() == 0) begin
            check_eq("unexpected_pulse", bus_if.out_valid, 1'b0);
         end else begin
            mon_e = sb.pop_front();
            check_eq("rk", bus_if.out_rk, mon_e.rk);
            check_eq("rk_last", bus_if.out_last, mon_e.last);
            check_eq("rk_nk", bus_if.out_nk, mon_e.nk);
            check_eq("rk_cycle", cyc, mon_e.cyc);
            if (obs_cnt < 15) obs_rk[obs_cnt] = bus_if.out_rk;
            obs_cnt++;
            if (mon_e.last) begin
               check_eq("ready_in_last", bus_if.in_ready, 1'b1);
               post_pend = 1'b1;
               post_exp = mon_e.rk;
            end
         end
      end else begin
         check_eq("idle_last", bus_if.out_last, 1'b0);
         if (post_pend) begin
`ifdef KEYEXP_ZEROIZE_EN
            check_eq("post_last_rk", bus_if.out_rk, 128'h0);
`else
            check_eq("post_last_rk", bus_if.out_rk, post_exp);
`endif
            post_pend = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      n_compared = 0;
      n_mismatched = 0;
      obs_cnt = 0;
      post_pend = 1'b0;
      post_exp = 128'h0;
      cyc = 0;
      rst = 1'b1;
      bus_if.in_valid = 1'b0;
      bus_if.in_key = 256'h0;
      bus_if.in_nk = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ready", bus_if.in_ready, 1'b1);
      check_eq("rst_valid", bus_if.out_valid, 1'b0);
      check_eq("rst_last", bus_if.out_last, 1'b0);
      check_eq("rst_rk", bus_if.out_rk, 128'h0);
      check_eq("rst_nk", bus_if.out_nk, 2'b00);
      rst = 1'b0;
      @(negedge clk);

      do_load(2'b00, K1);
      wait_drain(100);
      check_eq("a128_count", obs_cnt, 11);
      check_eq("a128_r1", obs_rk[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      check_eq("a128_r10", obs_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

      do_load(2'b00, K2);
      wait_drain(100);
      check_eq("fips_r10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      do_load(2'b01, K192);
      wait_drain(100);
      check_eq("a192_count", obs_cnt, 13);
      check_eq("a192_r12", obs_rk[12], 128'ha4970a331a78dc09c418c271e3a41d5d);

      do_load(2'b11, K256);
      wait_drain(100);
      check_eq("a256_count", obs_cnt, 15);
      check_eq("a256_r14", obs_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

      do_load(2'b00, K1);
      repeat (10) @(negedge clk);
      check_eq("busy_ready", bus_if.in_ready, 1'b0);
      bus_if.in_valid = 1'b1;
      bus_if.in_key = K2;
      bus_if.in_nk = 2'b10;
      repeat (3) @(negedge clk);
      bus_if.in_valid = 1'b0;
      wait_drain(100);
      check_eq("busy_r10", obs_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

      do_load(2'b00, K2);
      while (cyc < last_accept + 44) @(negedge clk);
      do_load(2'b00, K1);
      wait_drain(100);
      check_eq("b2b_r10", obs_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

      do_load(2'b00, K1);
      k = 0;
      while (obs_cnt < 3 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check_eq("abort_seen", obs_cnt, 3);
      rst = 1'b1;
      bus_if.in_valid = 1'b1;
      bus_if.in_key = K2;
      bus_if.in_nk = 2'b10;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus_if.in_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      check_eq("abort_ready", bus_if.in_ready, 1'b1);
      check_eq("abort_valid", bus_if.out_valid, 1'b0);
      repeat (70) @(negedge clk);
      check_eq("abort_no_more", obs_cnt, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
